// File: rtl/uart_tx_rx_if.sv
// Byte-level signal bundle between the UART message sequencer (master) and the 8N1 core (slave).
// Serial line pins travel with the bundle so the core exposes only clock, reset and this interface.
interface uart_tx_rx_if;
   logic       START;
   logic [7:0] UART_TX_DATA;
   logic       UART_TX_O;
   logic       TX_BUSY;
   logic       UART_RX_I;
   logic [7:0] UART_RX_DATA;
   logic       RX_VALID;

   modport master (
      output START, UART_TX_DATA, UART_RX_I,
      input  UART_TX_O, TX_BUSY, UART_RX_DATA, RX_VALID
   );

   modport slave (
      input  START, UART_TX_DATA, UART_RX_I,
      output UART_TX_O, TX_BUSY, UART_RX_DATA, RX_VALID
   );
endinterface

// File: rtl/uart_tx_rx.sv
// Full-duplex 8N1 UART core: independent transmitter and receiver on one clock.
// Define UART_LOOPBACK_EN to feed the receiver from the internal transmit line instead of UART_RX_I.
module uart_tx_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9_600
) (
   input logic          SYSCLK,
   input logic          RST_B,
   uart_tx_rx_if.slave  bus
);

   localparam int BIT_CNT = CLK_FREQ / BAUD;
   localparam int CW      = $clog2(BIT_CNT) + 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CNT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(7);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ------------------------------------------------------------------ transmitter
   tx_state_t         tx_state, tx_next;
   logic [CW-1:0]     tx_cnt;
   logic [CW-1:0]     tx_bit;
   logic [7:0]        tx_shift;
   logic              tx_tick;
   logic              tx_line;
   logic              tx_busy;

   assign tx_tick = (tx_cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge SYSCLK or negedge RST_B) begin
      if (!RST_B) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         tx_state <= tx_next;

         if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
         else                                tx_cnt <= tx_cnt + CNT_ONE;

         // Data is captured at the end of the start bit, giving the sequencer time to update it.
         if (tx_state == TX_START && tx_tick)     tx_shift <= bus.UART_TX_DATA;
         else if (tx_state == TX_DATA && tx_tick) tx_shift <= {1'b0, tx_shift[7:1]};

         if (tx_state != TX_DATA) tx_bit <= '0;
         else if (tx_tick)        tx_bit <= (tx_bit == BIT_LAST) ? '0 : tx_bit + CNT_ONE;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         TX_IDLE:  if (bus.START)                      tx_next = TX_START;
         TX_START: if (tx_tick)                        tx_next = TX_DATA;
         TX_DATA:  if (tx_tick && tx_bit == BIT_LAST)  tx_next = TX_STOP;
         TX_STOP:  if (tx_tick)                        tx_next = TX_IDLE;
         default:                                      tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_line = 1'b1;
      tx_busy = (tx_state != TX_IDLE);
      unique case (tx_state)
         TX_START: tx_line = 1'b0;
         TX_DATA:  tx_line = tx_shift[0];
         default:  tx_line = 1'b1;
      endcase
   end

   assign bus.UART_TX_O = tx_line;
   assign bus.TX_BUSY   = tx_busy;

   // ------------------------------------------------------------------ receiver
   logic rx_line;

`ifdef UART_LOOPBACK_EN
   assign rx_line = tx_line;
`else
   assign rx_line = bus.UART_RX_I;
`endif

   rx_state_t         rx_state, rx_next;
   logic              rx_meta, rx_sync, rx_prev;
   logic [CW-1:0]     rx_cnt;
   logic [CW-1:0]     rx_bit;
   logic [7:0]        rx_shift;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_tick;
   logic              rx_fall;
   logic              rx_publish;

   assign rx_tick = (rx_state == RX_START) ? (rx_cnt == CNT_HALF) : (rx_cnt == CNT_LAST);
   assign rx_fall = rx_prev & ~rx_sync;

   always_ff @(posedge SYSCLK or negedge RST_B) begin
      if (!RST_B) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_meta  <= rx_line;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_state <= rx_next;

         if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
         else                                rx_cnt <= rx_cnt + CNT_ONE;

         if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_sync, rx_shift[7:1]};

         if (rx_state != RX_DATA) rx_bit <= '0;
         else if (rx_tick)        rx_bit <= (rx_bit == BIT_LAST) ? '0 : rx_bit + CNT_ONE;

         if (rx_publish) rx_data <= rx_shift;
         rx_valid <= rx_publish;
      end
   end

   // A failed stop sample drops back to IDLE with the line low; the falling-edge detector
   // cannot fire again until the line has returned high, which is the re-arm condition.
   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         RX_IDLE:  if (rx_fall)                        rx_next = RX_START;
         RX_START: if (rx_tick)                        rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == BIT_LAST)  rx_next = RX_STOP;
         RX_STOP:  if (rx_tick)                        rx_next = RX_IDLE;
         default:                                      rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_publish = 1'b0;
      if (rx_state == RX_STOP && rx_tick && rx_sync) rx_publish = 1'b1;
   end

   assign bus.UART_RX_DATA = rx_data;
   assign bus.RX_VALID     = rx_valid;

endmodule

// File: tb/tb_uart_tx_rx.sv
// Directed bench for uart_tx_rx at BIT_CNT=16: TX framing, back-to-back stream, RX good/glitch/framing,
// async reset mid-frame, and (with UART_LOOPBACK_EN) an internal loopback byte.
module tb_uart_tx_rx;

   localparam int BC = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_rx_if bus ();

   uart_tx_rx #(.CLK_FREQ(160), .BAUD(10)) dut (
      .SYSCLK (clk),
      .RST_B  (rst_n),
      .bus    (bus)
   );

   int checks     = 0;
   int passes     = 0;
   int cycle      = 0;
   int valid_cnt  = 0;
   int last_valid = 0;

   always @(posedge clk) cycle++;
   always @(negedge clk) if (bus.RX_VALID === 1'b1) begin
      valid_cnt++;
      last_valid = cycle;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Entered on the first negedge with TX_BUSY high; samples each bit at its middle.
   task automatic capture_frame(input logic [7:0] next_data, output logic [9:0] frame,
                                output int busy_cycles);
      frame       = '0;
      busy_cycles = 0;
      while (bus.TX_BUSY === 1'b1 && busy_cycles < 400) begin
         if (busy_cycles % BC == BC / 2 && busy_cycles < 10 * BC)
            frame[busy_cycles / BC] = bus.UART_TX_O;
         if (busy_cycles == BC + 4) bus.UART_TX_DATA = next_data;
         busy_cycles++;
         @(negedge clk);
      end
   endtask

   // Single request; the data is only valid from the cycle after START rises.
   task automatic tx_frame(input logic [7:0] b, output logic [9:0] frame, output int len);
      @(negedge clk);
      bus.UART_TX_DATA = 8'h00;
      bus.START        = 1'b1;
      @(negedge clk);
      bus.START        = 1'b0;
      bus.UART_TX_DATA = b;
      capture_frame(b, frame, len);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      bus.UART_RX_I = 1'b0;
      repeat (BC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.UART_RX_I = b[i];
         repeat (BC) @(negedge clk);
      end
      bus.UART_RX_I = stop;
      repeat (BC) @(negedge clk);
      bus.UART_RX_I = 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [9:0] frame;
      int         len;
      int         v0;
      int         t0;
      string      msg;

      bus.START        = 1'b0;
      bus.UART_TX_DATA = 8'h00;
      bus.UART_RX_I    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx_o",    bus.UART_TX_O,    1);
      check("rst_busy",    bus.TX_BUSY,      0);
      check("rst_rx_data", bus.UART_RX_DATA, 8'h00);
      check("rst_rx_vld",  bus.RX_VALID,     0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 0x68 LSB first between start 0 and stop 1 -> 10'b1_01101000_0
      tx_frame(8'h68, frame, len);
      check("tx68_frame", frame, 10'h2D0);
      check("tx68_len",   len,   160);
      check("tx68_idle",  bus.UART_TX_O, 1);

      // Back-to-back stream with START held high.
      msg              = "hello world !\r\n";
      bus.UART_TX_DATA = msg[0];
      bus.START        = 1'b1;
      len = 0;
      while (bus.TX_BUSY !== 1'b1 && len < 50) begin
         @(negedge clk);
         len++;
      end
      check("b2b_first_busy", bus.TX_BUSY, 1);
      for (int f = 0; f < 15; f++) begin
         if (f == 14) bus.START = 1'b0;
         capture_frame((f < 14) ? msg[f + 1] : 8'h00, frame, len);
         check($sformatf("b2b_frame%0d", f), frame, {1'b1, msg[f], 1'b0});
         check($sformatf("b2b_len%0d", f),   len,   160);
         check($sformatf("b2b_gap%0d", f),   {bus.TX_BUSY, bus.UART_TX_O}, 2'b01);
         if (f < 14) begin
            @(negedge clk);
            check($sformatf("b2b_next%0d", f), bus.TX_BUSY, 1);
         end
      end
      repeat (5) @(negedge clk);

`ifndef UART_LOOPBACK_EN
      v0 = valid_cnt;
      t0 = cycle;
      send_rx(8'hA5, 1'b1);
      repeat (20) @(negedge clk);
      check("rxA5_pulse", valid_cnt - v0, 1);
      check("rxA5_data",  bus.UART_RX_DATA, 8'hA5);
      check("rxA5_time",  (last_valid - t0 >= 8 * BC) && (last_valid - t0 <= 10 * BC + 8), 1);

      v0 = valid_cnt;
      bus.UART_RX_I = 1'b0;
      repeat (4) @(negedge clk);
      bus.UART_RX_I = 1'b1;
      repeat (40) @(negedge clk);
      check("rx_glitch", valid_cnt - v0, 0);

      send_rx(8'h3C, 1'b0);
      repeat (40) @(negedge clk);
      check("rx_frm_pulse", valid_cnt - v0, 0);
      check("rx_frm_data",  bus.UART_RX_DATA, 8'hA5);

      send_rx(8'h5A, 1'b1);
      repeat (20) @(negedge clk);
      check("rx5A_pulse", valid_cnt - v0, 1);
      check("rx5A_data",  bus.UART_RX_DATA, 8'h5A);

      // TX and RX at the same time must not disturb each other.
      v0 = valid_cnt;
      fork
         send_rx(8'h96, 1'b1);
         tx_frame(8'hC3, frame, len);
      join
      repeat (20) @(negedge clk);
      check("dup_tx_frame", frame, {1'b1, 8'hC3, 1'b0});
      check("dup_rx_data",  bus.UART_RX_DATA, 8'h96);
      check("dup_rx_pulse", valid_cnt - v0, 1);
`endif

      // Asynchronous reset during data bit 3.
      @(negedge clk);
      bus.UART_TX_DATA = 8'h00;
      bus.START        = 1'b1;
      @(negedge clk);
      bus.START        = 1'b0;
      bus.UART_TX_DATA = 8'h68;
      repeat (4 * BC + 5) @(negedge clk);
      check("mid_busy_before", bus.TX_BUSY, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_tx_o",    bus.UART_TX_O,    1);
      check("mid_rst_busy",    bus.TX_BUSY,      0);
      check("mid_rst_rx_data", bus.UART_RX_DATA, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tx_frame(8'h68, frame, len);
      check("post_rst_frame", frame, 10'h2D0);
      check("post_rst_len",   len,   160);

`ifdef UART_LOOPBACK_EN
      bus.UART_RX_I = 1'b0;
      repeat (5) @(negedge clk);
      v0 = valid_cnt;
      tx_frame(8'h21, frame, len);
      repeat (30) @(negedge clk);
      check("lb_pulse", valid_cnt - v0, 1);
      check("lb_data",  bus.UART_RX_DATA, 8'h21);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
